// File: rtl/sprite_ram_loader_if.sv
// sprite_ram_loader_if
//   Byte-stream handshake into the sprite RAM loader.
//   in_data  : packed pixels, [3:0] = pixel n, [7:4] = pixel n+1
//   in_valid : in_data valid (driven by the source)
//   in_ready : loader accepts in_data this cycle (driven by the loader)
//   A transfer happens on a rising clock edge with in_valid & in_ready.
interface sprite_ram_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader
//   Writer side of the sprite memory. Accepts a byte stream of packed 4-bit
//   palette indices (low nibble first) and writes them, one pixel per cycle,
//   into an internal PIX_W x DEPTH RAM. A registered read port uses the
//   colour mapper's flat addressing (addr = x + y*WIDTH).
// Ports
//   Clk        in   system clock, all state on the rising edge
//   Reset      in   synchronous active-high reset (RAM contents are kept)
//   start      in   one-cycle pulse, begin loading an image at pixel 0
//   in_if      slave stream: in_data / in_valid / in_ready
//   busy       out  load in progress (start to done)
//   done       out  one-cycle pulse after the last pixel is written
//   wr_count   out  pixels written in the current/last load
//   rd_address in   read address from the colour mapper
//   rd_pixel   out  palette index at rd_address, one cycle later
module sprite_ram_loader #(
  parameter int WIDTH  = 199,
  parameter int HEIGHT = 107,
  parameter int DEPTH  = 32768,
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  sprite_ram_loader_if.slave   in_if,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    wr_count,
  input  logic [19:0]          rd_address,
  output logic [PIX_W-1:0]     rd_pixel
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [19:0]       NPIX_RD  = 20'(NPIX);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WR_LO,
    WR_HI,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_count_q, wr_count_d;
  logic [7:0]          data_q, data_d;
  logic [PIX_W-1:0]    rd_pixel_q;

  logic                mem_we;
  logic [PIX_W-1:0]    mem_wdata;
  logic [PIX_W-1:0]    mem [DEPTH];

  // State registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      wr_count_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      data_q     <= data_d;
    end
  end

  // Next state and outputs; in_ready is decoded from state only
  always_comb begin
    state_d        = state_q;
    wr_count_d     = wr_count_q;
    data_d         = data_q;
    mem_we         = 1'b0;
    mem_wdata      = '0;
    in_if.in_ready = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d    = RECV;
          wr_count_d = '0;
        end
      end
      RECV: begin
        in_if.in_ready = 1'b1;
        if (in_if.in_valid) begin
          data_d  = in_if.in_data;
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        mem_we     = 1'b1;
        mem_wdata  = data_q[3:0];
        wr_count_d = wr_count_q + 1'b1;
        state_d    = (wr_count_q == LAST_PIX) ? FIN : WR_HI;
      end
      WR_HI: begin
        mem_we     = 1'b1;
        mem_wdata  = data_q[7:4];
        wr_count_d = wr_count_q + 1'b1;
        state_d    = (wr_count_q == LAST_PIX) ? FIN : RECV;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_count = wr_count_q;

  // RAM write port; a reset cycle aborts the pending write
  always_ff @(posedge Clk) begin
    if (mem_we && !Reset) begin
      mem[wr_count_q] <= mem_wdata;
    end
  end

  // Registered read port, read-before-write on address collision
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_pixel_q <= '0;
    end else if (rd_address < NPIX_RD) begin
      rd_pixel_q <= mem[rd_address[ADDR_W-1:0]];
    end else begin
      rd_pixel_q <= '0;
    end
  end

  assign rd_pixel = rd_pixel_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
module tb_sprite_ram_loader;

  localparam int NPIX   = 21293;
  localparam int NBYTES = 10647;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [14:0] wr_count;
  logic [19:0] rd_address;
  logic [3:0]  rd_pixel;

  int checks;
  int errors;

  sprite_ram_loader_if s_if ();

  sprite_ram_loader #(
    .WIDTH  (199),
    .HEIGHT (107),
    .DEPTH  (32768),
    .ADDR_W (15),
    .PIX_W  (4)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .in_if      (s_if),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count),
    .rd_address (rd_address),
    .rd_pixel   (rd_pixel)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer a byte and return #1 after the edge it was accepted on.
  task automatic send_byte(input logic [7:0] b, input bit hold);
    int unsigned n;
    n = 0;
    s_if.in_data  = b;
    s_if.in_valid = 1'b1;
    while (!s_if.in_ready && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (s_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait: in_ready=%b required 1 after %0d cycles", s_if.in_ready, n);
    end
    step();
    if (!hold) s_if.in_valid = 1'b0;
  endtask

  task automatic read_pix(input logic [19:0] a, output logic [3:0] p);
    rd_address = a;
    step();
    p = rd_pixel;
  endtask

  function automatic logic [7:0] t3_byte(input int i);
    return (i == NBYTES - 1) ? 8'h5F : 8'(i * 7 + 3);
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    checks++;
    if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", s_if.in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++;
    if (wr_count !== 15'd0) begin errors++; $display("FAIL reset_wr_count: got %0d required 0", wr_count); end
    checks++;
    if (rd_pixel !== 4'd0) begin errors++; $display("FAIL reset_rd_pixel: got %h required 0", rd_pixel); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [3:0] p;
    logic [3:0] exp [4];
    exp = '{4'h1, 4'h2, 4'h3, 4'h4};
    pulse_start();
    checks++;
    if (busy !== 1'b1 || s_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_start: busy=%b in_ready=%b required 1 1", busy, s_if.in_ready);
    end
    send_byte(8'h21, 1'b0);
    send_byte(8'h43, 1'b0);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      read_pix(20'(i), p);
      checks++;
      if (p !== exp[i]) begin errors++; $display("FAIL basic_mem[%0d]: got %h required %h", i, p, exp[i]); end
    end
    read_pix(20'd1, p);
    rd_address = 20'd2;
    #2;
    checks++;
    if (rd_pixel !== 4'h2) begin errors++; $display("FAIL basic_latency_pre: got %h required 2", rd_pixel); end
    step();
    checks++;
    if (rd_pixel !== 4'h3) begin errors++; $display("FAIL basic_latency_post: got %h required 3", rd_pixel); end
    checks++;
    if (wr_count !== 15'd4) begin errors++; $display("FAIL basic_wr_count: got %0d required 4", wr_count); end
  endtask

  task automatic test_full_load();
    int dones;
    logic [3:0] p;
    int idx [7];
    logic [7:0] b;
    logic [3:0] e;
    idx = '{0, 1, 1000, 1001, 21290, 21291, 21292};
    do_reset();
    pulse_start();
    for (int i = 0; i < NBYTES; i++) send_byte(t3_byte(i), 1'b1);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL full_done_pulse: got %0d cycles required 1", dones); end
    checks++;
    if (wr_count !== 15'(NPIX)) begin errors++; $display("FAIL full_wr_count: got %0d required %0d", wr_count, NPIX); end
    checks++;
    if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_after: got %b required 0", s_if.in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %b required 0", busy); end
    s_if.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      b = t3_byte(idx[k] / 2);
      e = (idx[k] % 2 == 0) ? b[3:0] : b[7:4];
      read_pix(20'(idx[k]), p);
      checks++;
      if (p !== e) begin errors++; $display("FAIL full_mem[%0d]: got %h required %h", idx[k], p, e); end
    end
  endtask

  task automatic test_in_ready_gaps();
    logic [7:0] tbl [6];
    logic [3:0] p;
    logic [3:0] e;
    tbl = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h7E};
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      s_if.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      send_byte(tbl[i], 1'b0);
      checks++;
      if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL gap_ready_c1[%0d]: got %b required 0", i, s_if.in_ready); end
      step();
      checks++;
      if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL gap_ready_c2[%0d]: got %b required 0", i, s_if.in_ready); end
      step();
      checks++;
      if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL gap_ready_c3[%0d]: got %b required 1", i, s_if.in_ready); end
    end
    checks++;
    if (wr_count !== 15'd12) begin errors++; $display("FAIL gap_wr_count: got %0d required 12", wr_count); end
    for (int a = 0; a < 12; a++) begin
      e = (a % 2 == 0) ? tbl[a / 2][3:0] : tbl[a / 2][7:4];
      read_pix(20'(a), p);
      checks++;
      if (p !== e) begin errors++; $display("FAIL gap_mem[%0d]: got %h required %h", a, p, e); end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [3:0] p;
    logic [7:0] b;
    logic [3:0] e;
    do_reset();
    pulse_start();
    for (int i = 0; i < 100; i++) send_byte(8'(i * 13 + 5), 1'b1);
    s_if.in_valid = 1'b0;
    step();
    step();
    do_reset();
    checks++;
    if (busy !== 1'b0 || wr_count !== 15'd0 || s_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b wr_count=%0d in_ready=%b required 0 0 0", busy, wr_count, s_if.in_ready);
    end
    for (int a = 0; a < 200; a++) begin
      b = 8'((a / 2) * 13 + 5);
      e = (a % 2 == 0) ? b[3:0] : b[7:4];
      read_pix(20'(a), p);
      checks++;
      if (p !== e) begin errors++; $display("FAIL midreset_mem[%0d]: got %h required %h", a, p, e); end
    end
    pulse_start();
    send_byte(8'h77, 1'b0);
    step();
    step();
    for (int a = 0; a < 3; a++) begin
      e = (a < 2) ? 4'h7 : 4'h2;
      read_pix(20'(a), p);
      checks++;
      if (p !== e) begin errors++; $display("FAIL reload_mem[%0d]: got %h required %h", a, p, e); end
    end
  endtask

  task automatic test_start_ignored_and_range();
    logic [3:0] p;
    pulse_start();
    checks++;
    if (wr_count !== 15'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_ignored: wr_count=%0d busy=%b required 2 1", wr_count, busy);
    end
    send_byte(8'h98, 1'b0);
    send_byte(8'h6A, 1'b0);
    // In WR_LO now: mem[4] is written on the next edge while being read.
    rd_address = 20'd4;
    step();
    checks++;
    if (rd_pixel !== 4'hF) begin errors++; $display("FAIL collision_old: got %h required F", rd_pixel); end
    step();
    checks++;
    if (rd_pixel !== 4'hA) begin errors++; $display("FAIL collision_new: got %h required A", rd_pixel); end
    checks++;
    if (wr_count !== 15'd6) begin errors++; $display("FAIL restart_wr_count: got %0d required 6", wr_count); end
    read_pix(20'd2, p);
    checks++;
    if (p !== 4'h8) begin errors++; $display("FAIL restart_mem2: got %h required 8", p); end
    read_pix(20'd3, p);
    checks++;
    if (p !== 4'h9) begin errors++; $display("FAIL restart_mem3: got %h required 9", p); end
    read_pix(20'd21292, p);
    checks++;
    if (p !== 4'hF) begin errors++; $display("FAIL range_last: got %h required F", p); end
    read_pix(20'd21293, p);
    checks++;
    if (p !== 4'h0) begin errors++; $display("FAIL range_npix: got %h required 0", p); end
    read_pix(20'hFFFFF, p);
    checks++;
    if (p !== 4'h0) begin errors++; $display("FAIL range_max: got %h required 0", p); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    Reset         = 1'b1;
    start         = 1'b0;
    rd_address    = '0;
    s_if.in_data  = '0;
    s_if.in_valid = 1'b0;
    test_reset();
    test_basic();
    test_full_load();
    test_in_ready_gaps();
    test_reset_mid_load();
    test_start_ignored_and_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
